clk_div_prog: RTL and testbench
===============================

CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 Parameter WIDTH, default 8: bit width of the divisor, duty and counter paths.
REQ-002 Parameter DEFAULT_NUM, default 4: division ratio in force after reset; legal range 2..2^WIDTH-1.
REQ-003 Parameter DEFAULT_DUTY, default 2: high-phase length in clk_sig cycles after reset.
REQ-004 clk_sig  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_sig  input  1  asynchronous, active-high reset.
REQ-006 en_sig  input  1  run enable; level-sensitive.
REQ-007 cfg_valid  input  1  new configuration offered.
REQ-008 cfg_num  input  WIDTH  requested division ratio.
REQ-009 cfg_duty  input  WIDTH  requested high-phase length.
REQ-010 cfg_ready  output  1  high when the block can accept a configuration.
REQ-011 cnt_sig  output  WIDTH  registered phase counter, 0..num_act-1.
REQ-012 div_sig  output  1  registered divided output.
REQ-013 tick_sig  output  1  registered one-cycle pulse marking the start of each period.

Function
REQ-014 Internal state SHALL be: num_act, duty_act (active), num_pend, duty_pend, pend_flag, and run_flag (IDLE=0, RUN=1).
REQ-015 A configuration transfer SHALL occur on an edge where cfg_valid and cfg_ready are both 1; the edge sets pend_flag and captures num_pend and duty_pend.
REQ-016 cfg_ready SHALL equal not pend_flag.
REQ-017 Clamping at capture: cfg_num < 2 SHALL be stored as 2; cfg_duty > stored num SHALL be stored as that num.
REQ-018 Duty semantics: duty 0 SHALL give div_sig constantly 0; duty = num SHALL give div_sig constantly 1 while in RUN.
REQ-019 Edge with en_sig=0: run_flag, cnt_sig, div_sig and tick_sig SHALL all become 0; if pend_flag=1, the pending values SHALL be copied to the active values and pend_flag SHALL be cleared.
REQ-020 Edge with en_sig=1 and run_flag=0 (period start): apply the pending values if present, clear pend_flag, then set run_flag<=1, cnt_sig<=0, tick_sig<=1, div_sig<=(0 < duty_act after apply).
REQ-021 Edge with en_sig=1, run_flag=1 and cnt_sig < num_act-1: cnt_sig<=cnt_sig+1, tick_sig<=0, div_sig<=((cnt_sig+1) < duty_act).
REQ-022 Edge with en_sig=1, run_flag=1 and cnt_sig = num_act-1 (wrap): apply the pending values if present, clear pend_flag, then cnt_sig<=0, tick_sig<=1, div_sig<=(0 < duty_act after apply).
REQ-023 div_sig, cnt_sig and tick_sig SHALL be mutually aligned: all three are updated on the same edge from the new counter value, with no extra lag.
REQ-024 A configuration transferred on a wrap or start edge SHALL NOT affect that edge; it SHALL take effect at the next wrap, start, or disabled edge.
REQ-025 An active configuration SHALL never change mid-period; period length is always exactly num_act cycles.
REQ-026 All comparisons SHALL be unsigned at WIDTH bits; cnt_sig+1 SHALL NOT overflow, since cnt_sig < num_act-1 in that case.

Reset
REQ-027 While rst_sig=1, immediately and independent of clk_sig: cnt_sig=0, div_sig=0, tick_sig=0, run_flag=0, pend_flag=0, cfg_ready=1, num_act=DEFAULT_NUM, duty_act=DEFAULT_DUTY.
REQ-028 Reset asserted mid-period SHALL discard any pending configuration.
REQ-029 After reset release, the first edge with en_sig=1 SHALL be a period start per REQ-020.

Verification
REQ-030 Defaults: reset, then en_sig=1 for 12 cycles -> cnt_sig 0,1,2,3,0,..; div_sig 1,1,0,0 repeating; tick_sig high when cnt_sig=0.
REQ-031 Mid-period reconfig: running 4/2, offer num=5, duty=3 at cnt_sig=1 -> cfg_ready=0 until the wrap edge; the next period is 5 cycles with div_sig 1,1,1,0,0; cfg_ready=1 after the wrap.
REQ-032 Clamping: offer num=1, duty=9 while disabled, then enable -> num 2, duty 2; div_sig constantly 1; tick_sig every 2 cycles.
REQ-033 Boundary duties: num=6, duty=0 -> div_sig constantly 0 and tick_sig every 6 cycles; duty=6 -> div_sig constantly 1.
REQ-034 Offer on the wrap edge: cfg_valid coincident with the cnt_sig=num_act-1 edge -> the current new period keeps the old values; the following period uses the new values.
REQ-035 Reset mid-operation: assert rst_sig asynchronously at cnt_sig=2 with a pending configuration -> outputs go 0 before the next edge; after release and enable, the 4/2 pattern resumes and the pending values are lost.

Source files
------------

// File: rtl/clk_div_prog.sv
// Programmable clock divider with duty control and a one-deep
// configuration buffer applied only on period boundaries.
// Ports: clk_sig/rst_sig (async high), en_sig run enable,
//   cfg_valid/cfg_ready/cfg_num/cfg_duty config handshake,
//   cnt_sig phase counter, div_sig divided output,
//   tick_sig period-start pulse.
module clk_div_prog #(
  parameter int WIDTH        = 8,
  parameter int DEFAULT_NUM  = 4,
  parameter int DEFAULT_DUTY = 2
) (
  input  logic             clk_sig,
  input  logic             rst_sig,
  input  logic             en_sig,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_num,
  input  logic [WIDTH-1:0] cfg_duty,
  output logic             cfg_ready,
  output logic [WIDTH-1:0] cnt_sig,
  output logic             div_sig,
  output logic             tick_sig
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO  = WIDTH'(2);
  localparam logic [WIDTH-1:0] NUM_RST  = WIDTH'(DEFAULT_NUM);
  localparam logic [WIDTH-1:0] DUTY_RST = WIDTH'(DEFAULT_DUTY);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] num_act_q, num_act_d;
  logic [WIDTH-1:0] duty_act_q, duty_act_d;
  logic [WIDTH-1:0] num_pend_q, num_pend_d;
  logic [WIDTH-1:0] duty_pend_q, duty_pend_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             tick_q, tick_d;

  logic             take;
  logic             wrap;
  logic             bound;
  logic             apply;
  logic [WIDTH-1:0] num_clamp;
  logic [WIDTH-1:0] duty_clamp;
  logic [WIDTH-1:0] duty_eff;
  logic [WIDTH-1:0] cnt_inc;

  assign cfg_ready = ~pend_q;
  assign cnt_sig   = cnt_q;
  assign div_sig   = div_q;
  assign tick_sig  = tick_q;

  assign num_clamp  = (cfg_num < TWO) ? TWO : cfg_num;
  assign duty_clamp = (cfg_duty > num_clamp) ? num_clamp
                                             : cfg_duty;

  assign take    = cfg_valid & ~pend_q;
  assign wrap    = (state_q == RUN) &&
                   (cnt_q == num_act_q - ONE);
  // Disabled, start and wrap edges are the only
  // points where the active setting may change.
  assign bound   = ~en_sig | (state_q == IDLE) | wrap;
  assign apply   = bound & pend_q;
  assign duty_eff = apply ? duty_pend_q : duty_act_q;
  assign cnt_inc = cnt_q + ONE;

  always_comb begin
    state_d     = state_q;
    num_act_d   = num_act_q;
    duty_act_d  = duty_act_q;
    num_pend_d  = num_pend_q;
    duty_pend_d = duty_pend_q;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    tick_d      = tick_q;

    if (apply) begin
      num_act_d  = num_pend_q;
      duty_act_d = duty_pend_q;
      pend_d     = 1'b0;
    end

    // take implies pend_q=0, so never collides with apply.
    if (take) begin
      num_pend_d  = num_clamp;
      duty_pend_d = duty_clamp;
      pend_d      = 1'b1;
    end

    unique case (1'b1)
      ~en_sig: begin
        state_d = IDLE;
        cnt_d   = ZERO;
        div_d   = 1'b0;
        tick_d  = 1'b0;
      end
      en_sig & bound: begin
        state_d = RUN;
        cnt_d   = ZERO;
        tick_d  = 1'b1;
        div_d   = (duty_eff != ZERO);
      end
      en_sig & ~bound: begin
        cnt_d  = cnt_inc;
        tick_d = 1'b0;
        div_d  = (cnt_inc < duty_act_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sig or posedge rst_sig) begin
    if (rst_sig) begin
      state_q     <= IDLE;
      num_act_q   <= NUM_RST;
      duty_act_q  <= DUTY_RST;
      num_pend_q  <= ZERO;
      duty_pend_q <= ZERO;
      pend_q      <= 1'b0;
      cnt_q       <= ZERO;
      div_q       <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_act_q   <= num_act_d;
      duty_act_q  <= duty_act_d;
      num_pend_q  <= num_pend_d;
      duty_pend_q <= duty_pend_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      tick_q      <= tick_d;
    end
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Testbench for clk_div_prog: scenario tasks plus a
// random run, all checked against a period-level model.
module tb_clk_div_prog;

  logic       clk_sig = 1'b0;
  logic       rst_sig;
  logic       en_sig;
  logic       cfg_valid;
  logic [7:0] cfg_num;
  logic [7:0] cfg_duty;
  logic       cfg_ready;
  logic [7:0] cnt_sig;
  logic       div_sig;
  logic       tick_sig;

  int total = 0;
  int bad   = 0;

  // model state
  int m_num, m_duty, m_pnum, m_pduty, m_cnt;
  bit m_pend, m_run;
  logic [7:0] e_cnt;
  logic       e_div, e_tick, e_rdy;

  clk_div_prog #(
    .WIDTH(8), .DEFAULT_NUM(4), .DEFAULT_DUTY(2)
  ) dut (
    .clk_sig  (clk_sig),
    .rst_sig  (rst_sig),
    .en_sig   (en_sig),
    .cfg_valid(cfg_valid),
    .cfg_num  (cfg_num),
    .cfg_duty (cfg_duty),
    .cfg_ready(cfg_ready),
    .cnt_sig  (cnt_sig),
    .div_sig  (div_sig),
    .tick_sig (tick_sig)
  );

  always #5 clk_sig = ~clk_sig;

  function automatic void m_outs();
    e_cnt  = 8'(m_cnt);
    e_div  = m_run && (m_cnt < m_duty);
    e_tick = m_run && (m_cnt == 0);
    e_rdy  = !m_pend;
  endfunction

  function automatic void m_reset();
    m_num = 4; m_duty = 2;
    m_pnum = 0; m_pduty = 0;
    m_pend = 0; m_run = 0; m_cnt = 0;
    m_outs();
  endfunction

  // One period is m_num cycles; the high phase is the
  // first m_duty of them. Settings swap only at edges
  // where a new period begins or the divider is idle.
  function automatic void m_edge(bit en, bit v,
                                 int n, int d);
    bit take, boundary;
    take = v && !m_pend;
    boundary = !en || !m_run || (m_cnt == m_num - 1);
    if (boundary && m_pend) begin
      m_num = m_pnum; m_duty = m_pduty; m_pend = 0;
    end
    if (!en) begin
      m_run = 0; m_cnt = 0;
    end else if (boundary) begin
      m_run = 1; m_cnt = 0;
    end else begin
      m_cnt = m_cnt + 1;
    end
    if (take) begin
      m_pnum  = (n < 2) ? 2 : n;
      m_pduty = (d > m_pnum) ? m_pnum : d;
      m_pend  = 1;
    end
    m_outs();
  endfunction

  task automatic step(input bit en, input bit v,
                      input int n, input int d);
    en_sig = en; cfg_valid = v;
    cfg_num = 8'(n); cfg_duty = 8'(d);
    @(posedge clk_sig);
    m_edge(en, v, n, d);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_sig = 1'b1;
    en_sig = 0; cfg_valid = 0;
    cfg_num = 0; cfg_duty = 0;
    @(posedge clk_sig);
    #2 rst_sig = 1'b0;
    m_reset();
    #1;
  endtask

  task automatic test_reset();
    rst_sig = 1'b1; en_sig = 0; cfg_valid = 0;
    cfg_num = 0; cfg_duty = 0;
    m_reset();
    #2;
    total++;
    if ({cnt_sig, div_sig, tick_sig, cfg_ready} !==
        {e_cnt, e_div, e_tick, e_rdy}) begin
      bad++;
      $display("FAIL reset: got %h/%b/%b/%b want %h/%b/%b/%b",
        cnt_sig, div_sig, tick_sig, cfg_ready,
        e_cnt, e_div, e_tick, e_rdy);
    end
    @(posedge clk_sig);
    #2 rst_sig = 1'b0;
  endtask

  task automatic test_defaults();
    bit exp_div [4] = '{1, 1, 0, 0};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0, 0);
      total++;
      if ({cnt_sig, div_sig, tick_sig} !==
          {8'(i % 4), exp_div[i % 4], (i % 4) == 0}) begin
        bad++;
        $display("FAIL defaults[%0d]: got %0d/%b/%b want %0d/%b/%b",
          i, cnt_sig, div_sig, tick_sig,
          i % 4, exp_div[i % 4], (i % 4) == 0);
      end
    end
  endtask

  task automatic test_reconfig();
    bit exp_div [5] = '{1, 1, 1, 0, 0};
    int guard = 0;
    do_reset();
    step(1, 0, 0, 0);
    while (m_cnt != 1 && guard < 20) begin
      step(1, 0, 0, 0); guard++;
    end
    step(1, 1, 5, 3);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (cfg_ready !== 1'b0 ||
          cnt_sig !== 8'(2 + i)) begin
        bad++;
        $display("FAIL reconfig_wait: rdy=%b cnt=%0d want 0/%0d",
          cfg_ready, cnt_sig, 2 + i);
      end
      step(1, 0, 0, 0);
    end
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({cnt_sig, div_sig, tick_sig, cfg_ready} !==
          {8'(i % 5), exp_div[i % 5], (i % 5) == 0, 1'b1})
      begin
        bad++;
        $display("FAIL reconfig[%0d]: got %0d/%b/%b/%b",
          i, cnt_sig, div_sig, tick_sig, cfg_ready);
      end
      step(1, 0, 0, 0);
    end
  endtask

  task automatic test_clamp();
    do_reset();
    step(0, 1, 1, 9);
    step(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 0);
      total++;
      if ({cnt_sig, div_sig, tick_sig, cfg_ready} !==
          {8'(i % 2), 1'b1, (i % 2) == 0, 1'b1}) begin
        bad++;
        $display("FAIL clamp[%0d]: got %0d/%b/%b/%b",
          i, cnt_sig, div_sig, tick_sig, cfg_ready);
      end
    end
  endtask

  task automatic test_boundary();
    do_reset();
    step(0, 1, 6, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0, 0);
      total++;
      if ({cnt_sig, div_sig, tick_sig} !==
          {8'(i % 6), 1'b0, (i % 6) == 0}) begin
        bad++;
        $display("FAIL duty0[%0d]: got %0d/%b/%b",
          i, cnt_sig, div_sig, tick_sig);
      end
    end
    step(0, 1, 6, 6);
    step(0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0, 0);
      total++;
      if ({cnt_sig, div_sig, tick_sig} !==
          {8'(i % 6), 1'b1, (i % 6) == 0}) begin
        bad++;
        $display("FAIL dutyN[%0d]: got %0d/%b/%b",
          i, cnt_sig, div_sig, tick_sig);
      end
    end
  endtask

  task automatic test_wrap_offer();
    bit exp_old [4] = '{1, 1, 0, 0};
    bit exp_new [3] = '{1, 0, 0};
    int guard = 0;
    do_reset();
    step(1, 0, 0, 0);
    while (m_cnt != 3 && guard < 20) begin
      step(1, 0, 0, 0); guard++;
    end
    step(1, 1, 3, 1);
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({cnt_sig, div_sig} !== {8'(i), exp_old[i]}) begin
        bad++;
        $display("FAIL wrap_old[%0d]: got %0d/%b",
          i, cnt_sig, div_sig);
      end
      step(1, 0, 0, 0);
    end
    for (int i = 0; i < 6; i++) begin
      total++;
      if ({cnt_sig, div_sig, tick_sig} !==
          {8'(i % 3), exp_new[i % 3], (i % 3) == 0}) begin
        bad++;
        $display("FAIL wrap_new[%0d]: got %0d/%b/%b",
          i, cnt_sig, div_sig, tick_sig);
      end
      step(1, 0, 0, 0);
    end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    do_reset();
    step(1, 0, 0, 0);
    step(1, 1, 7, 1);
    total++;
    if (cfg_ready !== 1'b0 || cnt_sig !== 8'd1) begin
      bad++;
      $display("FAIL arst_pend: rdy=%b cnt=%0d want 0/1",
        cfg_ready, cnt_sig);
    end
    while (m_cnt != 2 && guard < 20) begin
      step(1, 0, 0, 0); guard++;
    end
    #3 rst_sig = 1'b1;
    #1;
    total++;
    if ({cnt_sig, div_sig, tick_sig, cfg_ready} !==
        {8'd0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL arst_now: got %0d/%b/%b/%b want 0/0/0/1",
        cnt_sig, div_sig, tick_sig, cfg_ready);
    end
    @(negedge clk_sig);
    rst_sig = 1'b0;
    m_reset();
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 0);
      total++;
      if ({cnt_sig, div_sig, tick_sig} !==
          {e_cnt, e_div, e_tick} ||
          cnt_sig !== 8'(i % 4)) begin
        bad++;
        $display("FAIL arst_resume[%0d]: got %0d/%b/%b want %0d/%b/%b",
          i, cnt_sig, div_sig, tick_sig,
          e_cnt, e_div, e_tick);
      end
    end
  endtask

  task automatic test_random();
    bit en, v;
    int n, d;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 15) != 0);
      v  = ($urandom_range(0, 3) == 0);
      n  = $urandom_range(0, 9);
      d  = $urandom_range(0, 11);
      step(en, v, n, d);
      total++;
      if ({cnt_sig, div_sig, tick_sig, cfg_ready} !==
          {e_cnt, e_div, e_tick, e_rdy}) begin
        bad++;
        $display("FAIL random[%0d]: got %0d/%b/%b/%b want %0d/%b/%b/%b",
          i, cnt_sig, div_sig, tick_sig, cfg_ready,
          e_cnt, e_div, e_tick, e_rdy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_reconfig();
    test_clamp();
    test_boundary();
    test_wrap_offer();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
